// File: rtl/mmc3_irq_counter.sv
// MMC3 scanline IRQ counter: filters PPU A12 rises into counter clocks and
// raises an active-low CPU IRQ when the down-counter reaches zero.
module mmc3_irq_counter #(
  parameter int A12_LOW_MIN   = 3,
  parameter bit NEW_BEHAVIOUR = 1'b1
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       ppu_a12,
  input  logic       reg_we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_data,
  output logic       irq
);

  localparam logic [1:0] SEL_LATCH   = 2'd0;
  localparam logic [1:0] SEL_RELOAD  = 2'd1;
  localparam logic [1:0] SEL_DISABLE = 2'd2;
  localparam logic [1:0] SEL_ENABLE  = 2'd3;
  localparam logic [2:0] LOW_MIN     = 3'(A12_LOW_MIN);

  logic       s1_reg, s2_reg, prev_reg;
  logic [2:0] low_cnt_reg, low_cnt_next;
  logic [7:0] latch_reg, latch_next;
  logic [7:0] counter_reg, counter_next, counter_evt;
  logic       reload_flag_reg, reload_flag_next, reload_evt;
  logic       irq_en_reg, irq_en_next;
  logic       irq_pend_reg, irq_pend_next;
  logic       clk_evt, pend_set;
  logic       wr_latch, wr_reload, wr_disable, wr_enable;

  assign wr_latch   = reg_we && (reg_sel == SEL_LATCH);
  assign wr_reload  = reg_we && (reg_sel == SEL_RELOAD);
  assign wr_disable = reg_we && (reg_sel == SEL_DISABLE);
  assign wr_enable  = reg_we && (reg_sel == SEL_ENABLE);

  // A rise only counts after A12 has been low long enough to reject
  // the short low glitches seen during sprite/background fetch overlap.
  assign clk_evt = s2_reg && !prev_reg && (low_cnt_reg >= LOW_MIN);

  always_comb begin
    low_cnt_next = 3'd0;
    if (!s2_reg) begin
      low_cnt_next = (low_cnt_reg == 3'd7) ? 3'd7 : low_cnt_reg + 3'd1;
    end
  end

  always_comb begin
    counter_evt = counter_reg;
    reload_evt  = reload_flag_reg;
    pend_set    = 1'b0;
    if (clk_evt) begin
      if ((counter_reg == 8'd0) || reload_flag_reg) begin
        counter_evt = latch_reg;
        reload_evt  = 1'b0;
      end else begin
        counter_evt = counter_reg - 8'd1;
      end
      if (NEW_BEHAVIOUR) begin
        pend_set = (counter_evt == 8'd0) && irq_en_reg;
      end else begin
        pend_set = (counter_evt == 8'd0) && irq_en_reg &&
                   ((counter_reg != 8'd0) || reload_flag_reg);
      end
    end
  end

  // Register writes are applied on top of the counter-clock result, so
  // a same-cycle clock always sees the old latch, counter, flag and enable.
  always_comb begin
    latch_next       = wr_latch ? reg_data : latch_reg;
    counter_next     = wr_reload ? 8'd0 : counter_evt;
    reload_flag_next = wr_reload ? 1'b1 : reload_evt;
    irq_en_next      = irq_en_reg;
    if (wr_enable) begin
      irq_en_next = 1'b1;
    end else if (wr_disable) begin
      irq_en_next = 1'b0;
    end
    irq_pend_next = wr_disable ? 1'b0 : (irq_pend_reg || pend_set);
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      s1_reg          <= 1'b0;
      s2_reg          <= 1'b0;
      prev_reg        <= 1'b0;
      low_cnt_reg     <= 3'd0;
      latch_reg       <= 8'd0;
      counter_reg     <= 8'd0;
      reload_flag_reg <= 1'b0;
      irq_en_reg      <= 1'b0;
      irq_pend_reg    <= 1'b0;
    end else begin
      s1_reg          <= ppu_a12;
      s2_reg          <= s1_reg;
      prev_reg        <= s2_reg;
      low_cnt_reg     <= low_cnt_next;
      latch_reg       <= latch_next;
      counter_reg     <= counter_next;
      reload_flag_reg <= reload_flag_next;
      irq_en_reg      <= irq_en_next;
      irq_pend_reg    <= irq_pend_next;
    end
  end

  assign irq = ~irq_pend_reg;

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Bench for mmc3_irq_counter: directed scenarios plus random A12/register
// traffic, both IRQ rules checked every cycle against a behavioural model.
module tb_mmc3_irq_counter;
  localparam int LOW_MIN = 3;

  logic       m2 = 1'b0;
  logic       reset = 1'b1;
  logic       ppu_a12 = 1'b0;
  logic       reg_we = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] reg_data = 8'd0;
  logic       irq_new, irq_old;

  int checks = 0;
  int errors = 0;

  always #5 m2 = ~m2;

  mmc3_irq_counter #(.A12_LOW_MIN(LOW_MIN), .NEW_BEHAVIOUR(1'b1)) dut_new (
    .m2(m2), .reset(reset), .ppu_a12(ppu_a12), .reg_we(reg_we),
    .reg_sel(reg_sel), .reg_data(reg_data), .irq(irq_new)
  );

  mmc3_irq_counter #(.A12_LOW_MIN(LOW_MIN), .NEW_BEHAVIOUR(1'b0)) dut_old (
    .m2(m2), .reset(reset), .ppu_a12(ppu_a12), .reg_we(reg_we),
    .reg_sel(reg_sel), .reg_data(reg_data), .irq(irq_old)
  );

  // Reference model state (plain integers and a sample history).
  bit a12_hist[$];
  int m_low_run;
  int m_latch, m_cnt;
  bit m_reload, m_en, m_pend_new, m_pend_old;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit s2, prev, evt, hit;
    int old_cnt;
    bit old_reload;
    if (reset) begin
      a12_hist = '{1'b0, 1'b0, 1'b0};
      m_low_run = 0;
      m_latch = 0; m_cnt = 0; m_reload = 0;
      m_en = 0; m_pend_new = 0; m_pend_old = 0;
      return;
    end
    s2   = a12_hist[1];
    prev = a12_hist[0];
    evt  = s2 && !prev && (m_low_run >= LOW_MIN);
    if (evt) begin
      old_cnt = m_cnt;
      old_reload = m_reload;
      if (m_cnt == 0 || m_reload) begin
        m_cnt = m_latch;
        m_reload = 0;
      end else begin
        m_cnt = m_cnt - 1;
      end
      hit = (m_cnt == 0) && m_en;
      if (hit) m_pend_new = 1;
      if (hit && (old_cnt != 0 || old_reload)) m_pend_old = 1;
    end
    if (reg_we) begin
      case (reg_sel)
        2'd0: m_latch = int'(reg_data);
        2'd1: begin m_reload = 1; m_cnt = 0; end
        2'd2: begin m_en = 0; m_pend_new = 0; m_pend_old = 0; end
        default: m_en = 1;
      endcase
    end
    m_low_run = s2 ? 0 : m_low_run + 1;
    a12_hist.push_back(ppu_a12);
    void'(a12_hist.pop_front());
  endtask

  task automatic tick();
    @(posedge m2);
    model_step();
    @(negedge m2);
    check_eq("irq_new", irq_new, !m_pend_new);
    check_eq("irq_old", irq_old, !m_pend_old);
    check_eq("counter_new", dut_new.counter_reg, m_cnt);
    check_eq("counter_old", dut_old.counter_reg, m_cnt);
  endtask

  task automatic seg(input bit v, input int n);
    ppu_a12 = v;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    reg_we = 1'b1; reg_sel = sel; reg_data = d;
    tick();
    reg_we = 1'b0; reg_data = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    a12_hist = '{1'b0, 1'b0, 1'b0};
    tick(); tick();
    reset = 1'b0;
    check_eq("reset_irq", irq_new, 1);
    check_eq("reset_counter", dut_new.counter_reg, 0);
    $display("txn reset: irq=%0b counter=%0d", irq_new, dut_new.counter_reg);

    // Countdown 3,2,1,0 with exact IRQ latency.
    wr(2'd0, 8'd3); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    for (int k = 0; k < 4; k++) begin
      seg(1'b0, 8);
      ppu_a12 = 1'b1;
      tick(); tick();
      check_eq("cd_pre_cnt", dut_new.counter_reg, (k == 0) ? 0 : 4 - k);
      check_eq("cd_pre_irq", irq_new, 1);
      tick();
      check_eq("cd_cnt", dut_new.counter_reg, 3 - k);
      check_eq("cd_irq", irq_new, (k == 3) ? 0 : 1);
      seg(1'b1, 5);
      $display("txn countdown %0d: counter=%0d irq=%0b", k, dut_new.counter_reg, irq_new);
    end

    // Disable acknowledges, re-enable and count down again.
    wr(2'd2, 8'd0);
    check_eq("ack_irq", irq_new, 1);
    wr(2'd3, 8'd0);
    for (int k = 0; k < 4; k++) begin
      seg(1'b0, 8); seg(1'b1, 8);
    end
    check_eq("reen_irq", irq_new, 0);
    $display("txn ack/reenable: irq=%0b", irq_new);

    // Reset mid-count with A12 high: short low period afterwards is rejected.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_irq", irq_new, 1);
    check_eq("rst_cnt", dut_new.counter_reg, 0);
    wr(2'd0, 8'd7);
    seg(1'b1, 4);
    check_eq("rst_norise", dut_new.counter_reg, 0);
    seg(1'b0, 2); seg(1'b1, 4);
    check_eq("rst_short", dut_new.counter_reg, 0);
    seg(1'b0, 3); seg(1'b1, 4);
    check_eq("rst_full", dut_new.counter_reg, 7);
    $display("txn reset midcount: counter=%0d", dut_new.counter_reg);

    // Short low periods are filtered.
    ppu_a12 = 1'b0;
    do_reset();
    wr(2'd0, 8'd5); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    seg(1'b0, 8); seg(1'b1, 4);
    check_eq("filt_first", dut_new.counter_reg, 5);
    repeat (5) begin
      seg(1'b0, 2); seg(1'b1, 2);
    end
    check_eq("filt_rest", dut_new.counter_reg, 5);
    $display("txn filter: counter=%0d", dut_new.counter_reg);

    // Disable write in the same cycle as the clock that reaches zero.
    do_reset();
    wr(2'd0, 8'd1); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    seg(1'b0, 8); seg(1'b1, 8);
    check_eq("race_setup", dut_new.counter_reg, 1);
    seg(1'b0, 8);
    ppu_a12 = 1'b1;
    tick(); tick();
    wr(2'd2, 8'd0);
    check_eq("race_cnt", dut_new.counter_reg, 0);
    check_eq("race_irq_new", irq_new, 1);
    check_eq("race_irq_old", irq_old, 1);
    seg(1'b1, 8);
    check_eq("race_irq_later", irq_new, 1);
    $display("txn disable race: irq=%0b counter=%0d", irq_new, dut_new.counter_reg);

    // Latch 0: new rule fires every clock, old rule only after reload.
    do_reset();
    wr(2'd0, 8'd0); wr(2'd3, 8'd0);
    seg(1'b0, 8); seg(1'b1, 8);
    check_eq("z0_new", irq_new, 0);
    check_eq("z0_old", irq_old, 1);
    wr(2'd2, 8'd0); wr(2'd3, 8'd0); wr(2'd1, 8'd0);
    seg(1'b0, 8); seg(1'b1, 8);
    check_eq("z1_new", irq_new, 0);
    check_eq("z1_old", irq_old, 0);
    wr(2'd2, 8'd0); wr(2'd3, 8'd0);
    seg(1'b0, 8); seg(1'b1, 8);
    check_eq("z2_new", irq_new, 0);
    check_eq("z2_old", irq_old, 1);
    $display("txn latch zero: irq_new=%0b irq_old=%0b", irq_new, irq_old);

    // Random A12 runs with random register writes and rare resets.
    for (int i = 0; i < 1500; i++) begin
      int n;
      ppu_a12 = ~ppu_a12;
      n = $urandom_range(1, 9);
      repeat (n) begin
        reg_we   = ($urandom_range(0, 5) == 0);
        reg_sel  = 2'($urandom);
        reg_data = 8'($urandom);
        reset    = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    reg_we = 1'b0;
    reset = 1'b0;
    tick();
    $display("txn random: done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmc3_irq_counter.md
MMC3_IRQ_COUNTER -- requirements
Module: mmc3_irq_counter

Interface
REQ-001 SHALL have parameter A12_LOW_MIN, default 3, giving the minimum number of m2 cycles PPU A12 must be low before a rise is counted (legal range 1..7).
REQ-002 SHALL have parameter NEW_BEHAVIOUR, default 1: 1 selects the Sharp/new IRQ rule, 0 selects the Rev-A rule.
REQ-003 SHALL have port m2, input, 1 bit: the sole clock (CPU M2); all state updates on posedge m2.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ppu_a12, input, 1 bit: raw PPU address bit 12, asynchronous to m2.
REQ-006 SHALL have port reg_we, input, 1 bit: single-cycle register write strobe from the mapper decoder.
REQ-007 SHALL have port reg_sel, input, 2 bits: 0 = latch ($C000), 1 = reload ($C001), 2 = disable/ack ($E000), 3 = enable ($E001).
REQ-008 SHALL have port reg_data, input, 8 bits: write data, used only when reg_sel = 0.
REQ-009 SHALL have port irq, output, 1 bit: active-low CPU IRQ request, driven directly to the cartridge irq pin.

Function
REQ-010 SHALL pass ppu_a12 through two flops (s1, s2) and a third history flop (prev), all clocked on m2.
REQ-011 SHALL keep a 3-bit low_cnt: it increments, saturating at 7, while s2 = 0, and clears to 0 while s2 = 1.
REQ-012 SHALL assert clk_evt for exactly one cycle when s2 = 1, prev = 0, and low_cnt >= A12_LOW_MIN.
REQ-013 SHALL ignore an A12 rise that follows a low period shorter than A12_LOW_MIN cycles; low_cnt still clears on that rise.
REQ-014 SHALL assert clk_evt on the 3rd posedge m2 after ppu_a12 rises, when the input is stable across those edges.
REQ-015 SHALL hold these 8-bit registers: latch and counter; and these flags: reload_flag, irq_en, irq_pend.
REQ-016 SHALL, on clk_evt, load counter with latch and clear reload_flag if counter = 0 or reload_flag = 1; otherwise it SHALL decrement counter by 1.
REQ-017 SHALL, with NEW_BEHAVIOUR = 1, set irq_pend on clk_evt when the resulting counter = 0 and irq_en = 1.
REQ-018 SHALL, with NEW_BEHAVIOUR = 0, set irq_pend only when the resulting counter = 0, irq_en = 1, and either the old counter was non-zero or reload_flag was 1.
REQ-019 SHALL, on a latch write, store reg_data into latch.
REQ-020 SHALL, on a reload write, set reload_flag and clear counter to 0.
REQ-021 SHALL, on a disable write, clear irq_en and clear irq_pend.
REQ-022 SHALL, on an enable write, set irq_en and leave irq_pend unchanged.
REQ-023 SHALL drive irq = ~irq_pend from a register, with no combinational path from any input.
REQ-024 SHALL give irq_pend a one-cycle latency from the clk_evt cycle to irq going low.
REQ-025 SHALL, when a latch write and clk_evt share a cycle, use the old latch value for the clk_evt reload.
REQ-026 SHALL, when a reload write and clk_evt share a cycle, evaluate clk_evt with the old counter and flag, then leave reload_flag = 1 and counter = 0 at cycle end.
REQ-027 SHALL, when a disable write and an irq_pend set share a cycle, let the disable win: irq_pend = 0 and irq stays high.
REQ-028 SHALL, when an enable write and clk_evt share a cycle, use the old irq_en value for REQ-017/018.
REQ-029 SHALL ignore reg_data when reg_sel != 0.
REQ-030 SHALL keep counter arithmetic 8-bit unsigned; a decrement never occurs from 0 (REQ-016 reloads instead), so no wrap-around is possible.

Reset
REQ-031 SHALL, on reset = 1 at posedge m2, clear latch, counter, reload_flag, irq_en, irq_pend, low_cnt, s1, s2 and prev, and drive irq = 1.
REQ-032 SHALL block clk_evt in the reset cycle and ignore reg_we while reset = 1.
REQ-033 SHALL, after reset mid-count, require a full A12_LOW_MIN low period before the first counted rise.

Verification
REQ-034 Scenario: latch = 3, reload, enable, then 4 filtered A12 rises (8 low, 8 high cycles each) -> counter sequence 3,2,1,0, and irq goes low 1 cycle after the 4th clk_evt.
REQ-035 Scenario: A12 pulses with 2 low cycles between rises, A12_LOW_MIN = 3 -> only the first rise counts; counter is unchanged by the rest.
REQ-036 Scenario: irq low, then a disable write -> irq high the next cycle; enable write plus a further clk_evt reaching 0 -> irq low again.
REQ-037 Scenario: latch = 0, NEW_BEHAVIOUR = 1, irq_en = 1 -> irq asserted on every clk_evt; with NEW_BEHAVIOUR = 0 -> asserted only on the clk_evt following a reload write.
REQ-038 Scenario: disable write coincident with the clk_evt that reaches 0 -> irq never goes low; counter = 0.
REQ-039 Scenario: reset asserted mid-count with irq low -> next cycle irq = 1 and counter = 0; the next rise needs 3 low cycles to count.
